// File: rtl/swipt_pkg.sv
// Shared definitions for the SWIPT frequency path.
//   state_t      : freq_tracker FSM encoding (also exported on the state port)
//   pll_err_t    : encoding of the PLL's two-bit error flag
//   DEFAULT_FREQ : frequency word loaded at reset and after any loss
package swipt_pkg;

  typedef enum logic [1:0] {
    ST_LOAD    = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_TRACK   = 2'd2,
    ST_HOLD    = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    PLL_OK      = 2'b00,
    PLL_EARLY   = 2'b01,
    PLL_LATE    = 2'b10,
    PLL_INVALID = 2'b11
  } pll_err_t;

  localparam logic [31:0] DEFAULT_FREQ = 32'h0000_9C40;

endpackage

// File: rtl/freq_tracker_if.sv
// Signal bundle between the frequency tracker, the PLL, SwiptOut and Heartbeat.
//   swipt_alive : link alive from Heartbeat
//   pll_phase   : PLL frequency estimate
//   pll_error   : PLL error flag (pll_err_t encoding)
//   freq        : frequency word to SwiptOut and the PLL
//   load_freq   : PLL reload request
//   locked      : lock indicator
//   state       : tracker FSM state, for observation
//
// Handshake: there is no valid/ready pair on this bundle. load_freq is a
// registered level, not a pulse: while it is high the PLL must keep reloading
// from freq every cycle; while it is low freq is a slewed target the PLL may
// follow freely. All tracker-driven signals change only on the clk edge.
interface freq_tracker_if
  import swipt_pkg::*;
#(
  parameter int W = 32
);
  logic         swipt_alive;
  logic [W-1:0] pll_phase;
  logic [1:0]   pll_error;
  logic [W-1:0] freq;
  logic         load_freq;
  logic         locked;
  state_t       state;

  modport master (
    input  swipt_alive, pll_phase, pll_error,
    output freq, load_freq, locked, state
  );

  modport slave (
    output swipt_alive, pll_phase, pll_error,
    input  freq, load_freq, locked, state
  );
endinterface

// File: rtl/slew_clamp.sv
// Combinational slew limiter and band clamp for the frequency word.
//   freq      : current output frequency
//   pll_phase : PLL frequency estimate
//   max_step  : largest allowed change per update
//   fmin/fmax : legal output band
//   freq_next : freq + clamp(pll_phase - freq, +-max_step), held in [fmin, fmax]
//   abs_d     : |pll_phase - freq|
module slew_clamp
  import swipt_pkg::*;
#(
  parameter int W = 32
) (
  input  logic [W-1:0] freq,
  input  logic [W-1:0] pll_phase,
  input  logic [W-1:0] max_step,
  input  logic [W-1:0] fmin,
  input  logic [W-1:0] fmax,
  output logic [W-1:0] freq_next,
  output logic [W-1:0] abs_d
);

  // The difference is taken one bit wider than the operands so that an
  // estimate near 0 or 2^W never wraps into the opposite direction.
  logic signed [W:0]   d;
  logic signed [W:0]   mag;
  logic signed [W:0]   step;
  logic signed [W+1:0] sum;
  logic signed [W+1:0] lo;
  logic signed [W+1:0] hi;

  always_comb begin
    d   = $signed({1'b0, pll_phase}) - $signed({1'b0, freq});
    mag = $signed({1'b0, max_step});
    if (d > mag)       step = mag;
    else if (d < -mag) step = -mag;
    else               step = d;

    sum = $signed({2'b00, freq}) + $signed({step[W], step});
    lo  = $signed({2'b00, fmin});
    hi  = $signed({2'b00, fmax});

    // An inverted band is a configuration error; pin the output to fmin.
    if (fmin > fmax)   freq_next = fmin;
    else if (sum < lo) freq_next = fmin;
    else if (sum > hi) freq_next = fmax;
    else               freq_next = sum[W-1:0];

    if (d[W]) abs_d = W'(-d);
    else      abs_d = d[W-1:0];
  end

endmodule

// File: rtl/freq_tracker.sv
// Closed-loop frequency controller between the PLL and SwiptOut.
// Waits a settle period in LOAD, then slews freq towards the PLL estimate on
// periodic update ticks (ACQUIRE), declares lock after a run of in-band ticks
// (TRACK), and freezes the output while the link is down (HOLD).
//   clk  : clock
//   nrst : synchronous reset, active high
//   bus  : freq_tracker_if master (swipt_alive, pll_phase, pll_error in;
//          freq, load_freq, locked, state out; all outputs registered)
module freq_tracker
  import swipt_pkg::*;
#(
  parameter int           W             = 32,
  parameter logic [W-1:0] DEFAULT_FREQ  = W'(swipt_pkg::DEFAULT_FREQ),
  parameter logic [W-1:0] FMIN          = W'(32'h0000_8000),
  parameter logic [W-1:0] FMAX          = W'(32'h0000_C000),
  parameter int           SETTLE_CYCLES = 1024,
  parameter int           UPDATE_DIV    = 64,
  parameter logic [W-1:0] MAX_STEP      = W'(32'h0000_0100),
  parameter logic [W-1:0] LOCK_TOL      = W'(32'h0000_0040),
  parameter int           LOCK_COUNT    = 16
) (
  input logic            clk,
  input logic            nrst,
  freq_tracker_if.master bus
);

  localparam int SET_W = $clog2(SETTLE_CYCLES + 1);
  localparam int DIV_W = $clog2(UPDATE_DIV + 1);
  localparam int LCK_W = $clog2(LOCK_COUNT + 1);
  localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_CYCLES - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(UPDATE_DIV - 1);
  localparam logic [LCK_W-1:0] LCK_LAST = LCK_W'(LOCK_COUNT - 1);

  state_t           state_q, state_d;
  logic [W-1:0]     freq_q, freq_d;
  logic             load_q, load_d;
  logic             locked_q, locked_d;
  logic [SET_W-1:0] settle_q, settle_d;
  logic [DIV_W-1:0] tick_q, tick_d;
  logic [LCK_W-1:0] good_q, good_d;
  logic [LCK_W-1:0] miss_q, miss_d;

  logic [W-1:0] slew_freq;
  logic [W-1:0] abs_d;
  logic         tracking;
  logic         tick;
  logic         invalid;
  logic         in_tol;
  logic         good_tick;

  slew_clamp #(.W(W)) u_slew_clamp (
    .freq      (freq_q),
    .pll_phase (bus.pll_phase),
    .max_step  (MAX_STEP),
    .fmin      (FMIN),
    .fmax      (FMAX),
    .freq_next (slew_freq),
    .abs_d     (abs_d)
  );

  assign tracking  = (state_q == ST_ACQUIRE) || (state_q == ST_TRACK);
  assign tick      = tracking && (tick_q == DIV_LAST);
  assign invalid   = (bus.pll_error == PLL_INVALID);
  assign in_tol    = (abs_d <= LOCK_TOL);
  assign good_tick = (bus.pll_error == PLL_OK) && in_tol;

  // State register
  always_ff @(posedge clk) begin
    if (nrst) state_q <= ST_LOAD;
    else      state_q <= state_d;
  end

  // Next-state logic; link loss outranks everything but reset, then error 11.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_LOAD: begin
        if (bus.swipt_alive && (settle_q == SET_LAST)) state_d = ST_ACQUIRE;
      end
      ST_ACQUIRE: begin
        if (!bus.swipt_alive)                               state_d = ST_HOLD;
        else if (tick && good_tick && (good_q == LCK_LAST)) state_d = ST_TRACK;
      end
      ST_TRACK: begin
        if (!bus.swipt_alive)                            state_d = ST_HOLD;
        else if (tick && invalid)                        state_d = ST_LOAD;
        else if (tick && !in_tol && (miss_q == LCK_LAST)) state_d = ST_ACQUIRE;
      end
      default: begin
        if (bus.swipt_alive) state_d = ST_LOAD;
      end
    endcase
  end

  // Output / counter logic: next values of the registered outputs and counters.
  always_comb begin
    freq_d   = freq_q;
    settle_d = '0;
    tick_d   = '0;
    good_d   = good_q;
    miss_d   = miss_q;
    case (state_q)
      ST_LOAD: begin
        settle_d = bus.swipt_alive ? settle_q + 1'b1 : settle_q;
        good_d   = '0;
        miss_d   = '0;
      end
      ST_ACQUIRE: begin
        tick_d = tick ? '0 : tick_q + 1'b1;
        miss_d = '0;
        if (tick) begin
          if (!invalid) freq_d = slew_freq;
          good_d = good_tick ? good_q + 1'b1 : '0;
        end
      end
      ST_TRACK: begin
        tick_d = tick ? '0 : tick_q + 1'b1;
        good_d = '0;
        if (tick && !invalid) begin
          freq_d = slew_freq;
          miss_d = in_tol ? '0 : miss_q + 1'b1;
        end
      end
      default: begin
        good_d = '0;
        miss_d = '0;
      end
    endcase

    // Every state starts with fresh counters, so the first tick after entering
    // ACQUIRE lands a full UPDATE_DIV cycles later.
    if (state_d != state_q) begin
      settle_d = '0;
      tick_d   = '0;
      good_d   = '0;
      miss_d   = '0;
    end

    // The destination state decides freq: LOAD forces the default, HOLD
    // freezes it even if a tick coincides with the link loss.
    case (state_d)
      ST_LOAD: freq_d = DEFAULT_FREQ;
      ST_HOLD: freq_d = freq_q;
      default: ;
    endcase

    load_d   = (state_d == ST_LOAD) || (state_d == ST_HOLD);
    locked_d = (state_d == ST_TRACK);
  end

  always_ff @(posedge clk) begin
    if (nrst) begin
      freq_q   <= DEFAULT_FREQ;
      load_q   <= 1'b1;
      locked_q <= 1'b0;
      settle_q <= '0;
      tick_q   <= '0;
      good_q   <= '0;
      miss_q   <= '0;
    end else begin
      freq_q   <= freq_d;
      load_q   <= load_d;
      locked_q <= locked_d;
      settle_q <= settle_d;
      tick_q   <= tick_d;
      good_q   <= good_d;
      miss_q   <= miss_d;
    end
  end

  assign bus.freq      = freq_q;
  assign bus.load_freq = load_q;
  assign bus.locked    = locked_q;
  assign bus.state     = state_q;

endmodule

// File: tb/tb_freq_tracker.sv
// Directed bench for freq_tracker with the default parameter set.
module tb_freq_tracker;
  import swipt_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic nrst;
  always #5 clk = ~clk;

  freq_tracker_if #(.W(32)) bus ();

  freq_tracker dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus)
  );

  // ---------------- bookkeeping ----------------
  int n_pass  = 0;
  int n_total = 0;
  logic [31:0] exp_f;

  // Cross n active edges and stop on the following falling edge.
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic chk_out(input string tag, input logic [31:0] f, input logic ld,
                         input logic lk, input state_t st);
    chk({tag, ".freq"},      bus.freq,             f);
    chk({tag, ".load_freq"}, 32'(bus.load_freq),   32'(ld));
    chk({tag, ".locked"},    32'(bus.locked),      32'(lk));
    chk({tag, ".state"},     32'(bus.state),       32'(st));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    nrst            = 1'b1;
    bus.swipt_alive = 1'b1;
    bus.pll_error   = 2'b00;
    bus.pll_phase   = 32'h9C40;
    @(negedge clk);
    cyc(2);
    nrst = 1'b0;
    chk_out("reset", 32'h9C40, 1'b1, 1'b0, ST_LOAD);

    // Settle: 1024 alive cycles in LOAD
    cyc(1023);
    chk_out("settle_end", 32'h9C40, 1'b1, 1'b0, ST_LOAD);
    cyc(1);
    chk_out("acquire_entry", 32'h9C40, 1'b0, 1'b0, ST_ACQUIRE);

    // Slew limit: first tick lands UPDATE_DIV cycles after entry
    bus.pll_phase = 32'h9E40;
    cyc(63);
    chk("slew_pre_tick", bus.freq, 32'h9C40);
    cyc(1);
    chk("slew_tick1", bus.freq, 32'h9D40);
    cyc(64);
    chk("slew_tick2", bus.freq, 32'h9E40);

    // Lock: phase kept 0x20 above freq; one 01 error after ten good ticks
    exp_f = 32'h9E40;
    for (int i = 0; i < 27; i++) begin
      bus.pll_error = (i == 10) ? 2'b01 : 2'b00;
      bus.pll_phase = exp_f + 32'h20;
      cyc(64);
      exp_f = exp_f + 32'h20;
      chk("lock_freq", bus.freq, exp_f);
      if (i == 10 || i == 25) chk("lock_early", 32'(bus.locked), 32'd0);
    end
    bus.pll_error = 2'b00;
    chk_out("locked", 32'hA1A0, 1'b0, 1'b1, ST_TRACK);

    // Clamp high: huge estimate must not wrap; 16 misses drop lock
    bus.pll_phase = 32'hFFFF_FFF0;
    for (int k = 1; k <= 32; k++) begin
      cyc(64);
      if (k == 15) chk_out("miss15", 32'hB0A0, 1'b0, 1'b1, ST_TRACK);
      if (k == 16) chk_out("miss16", 32'hB1A0, 1'b0, 1'b0, ST_ACQUIRE);
      if (k == 30) chk("clamp_hi_30", bus.freq, 32'hBFA0);
      if (k >= 31) chk("clamp_hi", bus.freq, 32'hC000);
    end

    // Clamp low
    bus.pll_phase = 32'h0000_0000;
    for (int k = 1; k <= 65; k++) begin
      cyc(64);
      if (k == 1)  chk("clamp_lo_1", bus.freq, 32'hBF00);
      if (k >= 64) chk("clamp_lo", bus.freq, 32'h8000);
    end

    // Relock at 8000
    bus.pll_phase = 32'h8000;
    for (int i = 0; i < 16; i++) begin
      cyc(64);
      if (i == 14) chk("relock_early", 32'(bus.locked), 32'd0);
    end
    chk_out("relocked", 32'h8000, 1'b0, 1'b1, ST_TRACK);

    // Link loss on a tick cycle
    cyc(63);
    bus.swipt_alive = 1'b0;
    bus.pll_phase   = 32'h9000;
    cyc(1);
    chk_out("hold_entry", 32'h8000, 1'b1, 1'b0, ST_HOLD);
    cyc(5);
    chk_out("hold_stay", 32'h8000, 1'b1, 1'b0, ST_HOLD);
    bus.swipt_alive = 1'b1;
    cyc(1);
    chk_out("hold_exit", 32'h9C40, 1'b1, 1'b0, ST_LOAD);

    // Settle counter pauses while the link is down in LOAD
    cyc(500);
    bus.swipt_alive = 1'b0;
    cyc(10);
    chk_out("load_dead", 32'h9C40, 1'b1, 1'b0, ST_LOAD);
    bus.swipt_alive = 1'b1;
    cyc(523);
    chk("load_paused", 32'(bus.state), 32'(ST_LOAD));
    cyc(1);
    chk("acq_after_pause", 32'(bus.state), 32'(ST_ACQUIRE));

    // Error 11 in ACQUIRE skips the update
    bus.pll_phase = 32'h9C60;
    bus.pll_error = 2'b11;
    cyc(64);
    chk_out("acq_err11", 32'h9C40, 1'b0, 1'b0, ST_ACQUIRE);
    bus.pll_error = 2'b00;
    cyc(64);
    chk("acq_after_err", bus.freq, 32'h9C60);
    cyc(64 * 15);
    chk_out("lock3", 32'h9C60, 1'b0, 1'b1, ST_TRACK);

    // Error 11 on a TRACK tick
    bus.pll_phase = 32'h9D00;
    bus.pll_error = 2'b11;
    cyc(64);
    chk_out("track_err11", 32'h9C40, 1'b1, 1'b0, ST_LOAD);
    bus.pll_error = 2'b00;

    // Reset pulse mid-ACQUIRE
    bus.pll_phase = 32'h9D40;
    cyc(1024);
    chk("acq4", 32'(bus.state), 32'(ST_ACQUIRE));
    cyc(64);
    chk("acq4_tick", bus.freq, 32'h9D40);
    cyc(20);
    nrst = 1'b1;
    cyc(1);
    chk_out("mid_reset", 32'h9C40, 1'b1, 1'b0, ST_LOAD);
    nrst = 1'b0;
    cyc(1);
    chk_out("post_reset", 32'h9C40, 1'b1, 1'b0, ST_LOAD);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
